// File: rtl/branch_redirect_ctrl_if.sv
// EX-stage / PC-mux / pipeline-register bundle for branch_redirect_ctrl.
// master = EX stage and consumers, slave = redirect controller.
interface branch_redirect_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              ex_valid;
    logic              ex_branch;
    logic              ex_jump;
    logic              branch_condition;
    logic [ADDR_W-1:0] ex_target;
    logic              stall_in;
    logic              pc_sel;
    logic [ADDR_W-1:0] pc_target;
    logic              flush_ifid;
    logic              flush_idex;
    logic              ctrl_busy;
    logic [CNT_W-1:0]  taken_cnt;
    logic [CNT_W-1:0]  nottaken_cnt;

    modport master (
        output ex_valid, ex_branch, ex_jump, branch_condition, ex_target, stall_in,
        input  pc_sel, pc_target, flush_ifid, flush_idex, ctrl_busy, taken_cnt, nottaken_cnt
    );

    modport slave (
        input  ex_valid, ex_branch, ex_jump, branch_condition, ex_target, stall_in,
        output pc_sel, pc_target, flush_ifid, flush_idex, ctrl_busy, taken_cnt, nottaken_cnt
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Redirect sequencer: turns a taken EX branch/jump into a PC redirect plus a fixed flush window.
// Optional branch statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_redirect_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_redirect_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] LP_CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_pc_sel;
    logic [ADDR_W-1:0] r_pc_target;
    logic              r_flush;
    logic              r_busy;
    logic              w_taken;

    assign w_taken = bus.ex_valid & ((bus.ex_branch & bus.branch_condition) | bus.ex_jump);

    // Redirect FSM with registered pc_sel/target/flush/busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_cnt       <= 4'd0;
            r_pc_sel    <= 1'b0;
            r_pc_target <= {ADDR_W{1'b0}};
            r_flush     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_taken && !bus.stall_in) begin
                        r_pc_target <= bus.ex_target;
                        r_pc_sel    <= 1'b1;
                        r_flush     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cnt       <= LP_CNT_INIT;
                        r_state     <= ST_FLUSH;
                    end else if (w_taken) begin
                        r_pc_target <= bus.ex_target;
                        r_pc_sel    <= 1'b0;
                        r_flush     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_PEND;
                    end else begin
                        r_pc_sel    <= 1'b0;
                        r_flush     <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                ST_PEND: begin
                    // EX is frozen here; the target was already captured on entry
                    if (!bus.stall_in) begin
                        r_pc_sel <= 1'b1;
                        r_flush  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_cnt    <= LP_CNT_INIT;
                        r_state  <= ST_FLUSH;
                    end else begin
                        r_pc_sel <= 1'b0;
                        r_flush  <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    r_pc_sel <= 1'b0;
                    if (r_cnt != 4'd0) begin
                        r_cnt   <= r_cnt - 4'd1;
                        r_flush <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_flush <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_cnt    <= 4'd0;
                    r_pc_sel <= 1'b0;
                    r_flush  <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_sel     = r_pc_sel;
    assign bus.pc_target  = r_pc_target;
    assign bus.flush_ifid = r_flush;
    assign bus.flush_idex = r_flush;
    assign bus.ctrl_busy  = r_busy;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_nottaken_cnt;
    logic             w_count;

    assign w_count = (r_state == ST_RUN) & bus.ex_valid & bus.ex_branch & ~bus.stall_in;

    // Saturating taken / not-taken counters, only for right-path branches seen in RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_taken_cnt    <= {CNT_W{1'b0}};
            r_nottaken_cnt <= {CNT_W{1'b0}};
        end else if (w_count && bus.branch_condition) begin
            if (r_taken_cnt != {CNT_W{1'b1}}) begin
                r_taken_cnt <= r_taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_taken_cnt <= r_taken_cnt;
            end
        end else if (w_count) begin
            if (r_nottaken_cnt != {CNT_W{1'b1}}) begin
                r_nottaken_cnt <= r_nottaken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_nottaken_cnt <= r_nottaken_cnt;
            end
        end else begin
            r_taken_cnt    <= r_taken_cnt;
            r_nottaken_cnt <= r_nottaken_cnt;
        end
    end

    assign bus.taken_cnt    = r_taken_cnt;
    assign bus.nottaken_cnt = r_nottaken_cnt;
`else
    assign bus.taken_cnt    = {CNT_W{1'b0}};
    assign bus.nottaken_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios plus random traffic
// compared against a cycle-level reference model of the redirect rules.
module tb_branch_redirect_ctrl;
    localparam int ADDR_W = 32;
    localparam int FC     = 2;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    branch_redirect_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    branch_redirect_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    bit              m_pc_sel, m_flush, m_busy, m_pend;
    logic [31:0]     m_target;
    int              m_left, m_tc, m_ntc;

    task automatic model_reset();
        m_pc_sel = 1'b0; m_flush = 1'b0; m_busy = 1'b0; m_pend = 1'b0;
        m_target = 32'd0; m_left = 0; m_tc = 0; m_ntc = 0;
    endtask

    task automatic start_window();
        m_left = FC; m_pc_sel = 1'b1; m_flush = 1'b1; m_busy = 1'b1; m_pend = 1'b0;
    endtask

    task automatic model_edge(input bit v, input bit b, input bit j, input bit c,
                              input logic [31:0] t, input bit s);
        bit taken;
        taken = v && ((b && c) || j);
        if (m_left > 0) begin
            m_left   = m_left - 1;
            m_pc_sel = 1'b0;
            m_flush  = (m_left > 0);
            m_busy   = m_flush;
        end else if (m_pend) begin
            if (!s) start_window();
        end else begin
            if (STATS && v && b && !s) begin
                if (c) m_tc  = (m_tc  < CMAX) ? m_tc + 1  : m_tc;
                else   m_ntc = (m_ntc < CMAX) ? m_ntc + 1 : m_ntc;
            end
            if (taken) begin
                m_target = t;
                if (s) begin
                    m_pend = 1'b1; m_busy = 1'b1; m_pc_sel = 1'b0; m_flush = 1'b0;
                end else begin
                    start_window();
                end
            end else begin
                m_pc_sel = 1'b0; m_flush = 1'b0; m_busy = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".pc_sel"},     64'(bus.pc_sel),       64'(m_pc_sel));
        chk({where, ".pc_target"},  64'(bus.pc_target),    64'(m_target));
        chk({where, ".flush_ifid"}, 64'(bus.flush_ifid),   64'(m_flush));
        chk({where, ".flush_idex"}, 64'(bus.flush_idex),   64'(m_flush));
        chk({where, ".ctrl_busy"},  64'(bus.ctrl_busy),    64'(m_busy));
        chk({where, ".taken_cnt"},  64'(bus.taken_cnt),    64'(m_tc));
        chk({where, ".nottaken"},   64'(bus.nottaken_cnt), 64'(m_ntc));
    endtask

    task automatic cycle(input string where, input bit v, input bit b, input bit j, input bit c,
                         input logic [31:0] t, input bit s);
        bus.ex_valid = v; bus.ex_branch = b; bus.ex_jump = j;
        bus.branch_condition = c; bus.ex_target = t; bus.stall_in = s;
        @(posedge clk);
        model_edge(v, b, j, c, t, s);
        #1;
        check_all(where);
    endtask

    task automatic idle(input string where, input int n);
        for (int i = 0; i < n; i++) cycle(where, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    endtask

    initial begin
        compared = 0; mismatched = 0;
        rst = 1'b1;
        bus.ex_valid = 1'b0; bus.ex_branch = 1'b0; bus.ex_jump = 1'b0;
        bus.branch_condition = 1'b0; bus.ex_target = 32'd0; bus.stall_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // 1: taken branch, default 2-cycle window
        cycle("t1.taken", 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0);
        chk("t1.pc_sel_first", 64'(bus.pc_sel), 64'd1);
        chk("t1.target", 64'(bus.pc_target), 64'h40);
        cycle("t1.win2", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("t1.flush_second", 64'(bus.flush_ifid), 64'd1);
        chk("t1.pc_sel_second", 64'(bus.pc_sel), 64'd0);
        cycle("t1.end", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("t1.busy_end", 64'(bus.ctrl_busy), 64'd0);

        // 2: not-taken branch
        cycle("t2.nt", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0080, 1'b0);
        chk("t2.no_sel", 64'(bus.pc_sel), 64'd0);
        idle("t2.idle", 1);

        // 3: jump while stalled for 3 cycles
        cycle("t3.s0", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 1'b1);
        cycle("t3.s1", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 1'b1);
        cycle("t3.s2", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 1'b1);
        chk("t3.pend_busy", 64'(bus.ctrl_busy), 64'd1);
        chk("t3.pend_nosel", 64'(bus.pc_sel), 64'd0);
        cycle("t3.release", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 1'b0);
        chk("t3.sel", 64'(bus.pc_sel), 64'd1);
        chk("t3.target", 64'(bus.pc_target), 64'h100);
        idle("t3.win", 3);

        // 4: taken branch every cycle, including through flush windows
        for (int i = 0; i < 9; i++)
            cycle("t4.stream", 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1000 + 32'(i * 4), 1'b0);
        idle("t4.idle", 2);

        // 5: reset mid-flush
        cycle("t5.taken", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_2000, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("t5.rst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("t5.rst_held");
        idle("t5.after", 2);
        cycle("t5.again", 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_3000, 1'b0);
        idle("t5.win", 2);

        // 6: counter saturation over 17 taken branches
        for (int i = 0; i < 17; i++) begin
            cycle("t6.br", 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_4000 + 32'(i), 1'b0);
            idle("t6.win", FC);
        end
        chk("t6.sat", 64'(bus.taken_cnt), STATS ? 64'hF : 64'd0);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle("rand",
                  1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 5) == 0),
                  1'($urandom), 32'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
